ma_decimator: RTL and testbench

- Downstream stage of the 9-tap moving-average filter. Its din connects to the filter's dout, and it shares the same ce.
- Keeps one of every N ce-qualified samples, where N is a runtime ratio. Kept samples are buffered in a small FIFO.
- Drains the FIFO onto an AXI-Stream master (tdata/tvalid/tready) for DMA or the next DSP stage.
- Flags dropped samples with a sticky overflow bit.

---
 rtl/ma_decimator_pkg.sv | 19 +
 rtl/ma_dec_fifo.sv | 59 +++++
 rtl/ma_decimator.sv | 137 +++++++++++++
 tb/tb_ma_decimator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_decimator_pkg.sv
// Shared widths and the FIFO entry type for the ma_decimator block.
// With MA_DEC_TLAST_EN defined, each FIFO entry also carries a tlast bit.
package ma_decimator_pkg;

    localparam int MA_DATA_WIDTH = 16;
    localparam int MA_FIFO_DEPTH = 4;
    localparam int PTR_W         = $clog2(MA_FIFO_DEPTH);

    localparam int                    DROP_CNT_W   = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

    typedef struct packed {
`ifdef MA_DEC_TLAST_EN
        logic                            last;
`endif
        logic signed [MA_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ma_dec_fifo.sv
// Small synchronous FIFO with an extra pointer bit for full/empty and a head
// output that is a pure mux of flops (no combinational path from push/pop).
module ma_dec_fifo
    import ma_decimator_pkg::*;
#(
    parameter int WIDTH = $bits(fifo_entry_t),
    parameter int DEPTH = MA_FIFO_DEPTH,
    parameter int AW    = PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO alongside a pop overwrites the slot being popped;
    // head still presents the old entry for this cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ma_decimator.sv
// Keeps one of every N ce-qualified samples, buffers them and drains them onto
// an AXI-Stream master. Optional MA_DEC_TLAST_EN adds m_axis_tlast framing.
module ma_decimator
    import ma_decimator_pkg::*;
#(
    parameter int DATA_WIDTH  = MA_DATA_WIDTH,
    parameter int RATIO_WIDTH = 8,
    parameter int FIFO_DEPTH  = MA_FIFO_DEPTH,
    parameter int FRAME_LEN   = 256
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         ce,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic [RATIO_WIDTH-1:0]       ratio,
    input  logic                         clear,
    output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
`ifdef MA_DEC_TLAST_EN
    output logic                         m_axis_tlast,
`endif
    output logic                         overflow,
    output logic [DROP_CNT_W-1:0]        drop_count
);

    localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);

    logic [RATIO_WIDTH-1:0] phase_q, phase_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [RATIO_WIDTH-1:0] ratio_in, eff_ratio;
    logic                   keep, push, pop, drop;
    logic                   fifo_full, fifo_empty;
    logic                   overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    fifo_entry_t            push_entry, head_entry;

    // While the latched ratio is 1 a new ratio takes effect on the very sample
    // being kept; otherwise it is only loaded on the last sample of an interval.
    always_comb begin
        ratio_in  = (ratio == '0) ? ONE : ratio;
        eff_ratio = (ratio_q == ONE) ? ratio_in : ratio_q;
        keep      = ce && (phase_q == '0);
        phase_d   = phase_q;
        ratio_d   = ratio_q;
        if (ce) begin
            phase_d = (phase_q == eff_ratio - ONE) ? '0 : phase_q + ONE;
            if (phase_q == ratio_q - ONE) begin
                ratio_d = ratio_in;
            end
        end
    end

    always_comb begin
        pop        = !fifo_empty && m_axis_tready;
        push       = keep && (!fifo_full || pop);
        drop       = keep && fifo_full && !pop;
        overflow_d = clear ? 1'b0 : overflow_q;
        drop_cnt_d = clear ? '0 : drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != DROP_CNT_MAX) begin
                drop_cnt_d = drop_cnt_d + 1'b1;
            end
        end
    end

`ifdef MA_DEC_TLAST_EN
    localparam int FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_end;

    // Every accepted push becomes exactly one transfer, in order, so counting
    // accepted pushes marks the same sample as counting handshakes would.
    always_comb begin
        push_entry      = '0;
        push_entry.data = din;
        frame_end       = (frame_q == FRAME_W'(FRAME_LEN - 1));
        push_entry.last = frame_end;
        frame_d         = frame_q;
        if (push) begin
            frame_d = frame_end ? '0 : frame_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign m_axis_tlast = head_entry.last;
`else
    always_comb begin
        push_entry      = '0;
        push_entry.data = din;
    end
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q    <= '0;
            ratio_q    <= ONE;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            ratio_q    <= ratio_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ma_dec_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .AW    ($clog2(FIFO_DEPTH))
    ) u_fifo (
        .clk   (clk),
        .rst_n (aresetn),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .head  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_axis_tdata  = head_entry.data;
    assign m_axis_tvalid = !fifo_empty;
    assign overflow      = overflow_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_ma_decimator.sv
// Self-checking bench for ma_decimator: directed scenarios plus a randomized
// run against a countdown/queue reference model. Honours MA_DEC_TLAST_EN.
module tb_ma_decimator;

    localparam int DEPTH    = 4;
    localparam int FRAME_TB = 4;

    logic               clk = 1'b0;
    logic               aresetn, ce, clear, tready;
    logic signed [15:0] din;
    logic [7:0]         ratio;
    logic signed [15:0] tdata;
    logic               tvalid, ovf;
    logic [15:0]        dcnt;
    logic               tlast;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          left, interval, m_dcnt, m_frame;
    bit          m_ovf, exp_valid, exp_last;
    logic [15:0] exp_data;
    logic [16:0] q[$];
    logic [15:0] dut_outs[$];
    bit          dut_lasts[$];

    always #5 clk = ~clk;

    ma_decimator #(
        .DATA_WIDTH (16),
        .RATIO_WIDTH(8),
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FRAME_TB)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .ce           (ce),
        .din          (din),
        .ratio        (ratio),
        .clear        (clear),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
`ifdef MA_DEC_TLAST_EN
        .m_axis_tlast (tlast),
`endif
        .overflow     (ovf),
        .drop_count   (dcnt)
    );

`ifndef MA_DEC_TLAST_EN
    assign tlast = 1'b0;
`endif

    task automatic model_clear();
        left = 0; interval = 1; m_ovf = 0; m_dcnt = 0; m_frame = 0;
        q.delete(); exp_valid = 0; exp_last = 0; exp_data = '0;
        dut_outs.delete(); dut_lasts.delete();
    endtask

    // Advance one clock: update model from the inputs the DUT is about to see,
    // record DUT handshakes, then sample 1 ns after the edge.
    task automatic cycle();
        int r, sz;
        bit keep_s, pop_s, drop_s;
        keep_s = 0; drop_s = 0;
        if (ce) begin
            r = (ratio == 0) ? 1 : int'(ratio);
            if (left == 0) begin
                keep_s = 1;
                if (interval == 1) interval = r;
                left = interval - 1;
            end else begin
                left--;
            end
            if (left == 0) interval = r;
        end
        sz    = q.size();
        pop_s = (sz != 0) && tready;
        if (pop_s) void'(q.pop_front());
        if (keep_s) begin
            if (sz < DEPTH || pop_s) begin
                q.push_back({(m_frame == FRAME_TB - 1), din});
                m_frame = (m_frame == FRAME_TB - 1) ? 0 : m_frame + 1;
            end else begin
                drop_s = 1;
            end
        end
        if (clear) begin m_ovf = 0; m_dcnt = 0; end
        if (drop_s) begin
            m_ovf = 1;
            if (m_dcnt < 65535) m_dcnt++;
        end
        if (tvalid && tready) begin
            dut_outs.push_back(tdata);
            dut_lasts.push_back(tlast);
        end
        @(posedge clk);
        #1;
        exp_valid = (q.size() != 0);
        if (exp_valid) begin
            exp_data = q[0][15:0];
            exp_last = q[0][16];
        end
    endtask

    task automatic do_reset();
        aresetn = 0; ce = 0; clear = 0; tready = 0; din = '0; ratio = 8'd1;
        model_clear();
        @(negedge clk);
        aresetn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 0; ce = 0; clear = 0; tready = 0; din = 16'sd77; ratio = 8'd1;
        #2;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        checks++; if (tdata !== 16'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", ovf); end
        checks++; if (dcnt !== 16'd0) begin errors++; $display("FAIL reset_drop_count got %0d want 0", dcnt); end
`ifdef MA_DEC_TLAST_EN
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
`endif
        do_reset();
    endtask

    task automatic test_passthrough();
        do_reset();
        ratio = 8'd1; tready = 1;
        for (int i = 1; i <= 20; i++) begin
            ce = 1; din = 16'(i);
            cycle();
            checks++;
            if (tvalid !== 1'b1 || tdata !== 16'(i)) begin
                errors++; $display("FAIL passthrough_out i=%0d got v=%b d=%0d want v=1 d=%0d", i, tvalid, tdata, i);
            end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL passthrough_ovf got %b want 0", ovf); end
        end
        ce = 0; cycle();
    endtask

    task automatic test_ratio4();
        logic [15:0] e[4];
        e = '{16'd0, 16'd4, 16'd8, 16'd12};
        do_reset();
        ratio = 8'd4; tready = 1;
        for (int c = 0; c < 50; c++) begin
            ce  = (c % 3 == 0) && (c < 48);
            din = ce ? 16'(c / 3) : 16'($urandom);
            cycle();
            checks++;
            if (tvalid !== exp_valid || (exp_valid && tdata !== exp_data)) begin
                errors++; $display("FAIL ratio4_cycle c=%0d got v=%b d=%0d want v=%b d=%0d", c, tvalid, tdata, exp_valid, exp_data);
            end
        end
        checks++;
        if (dut_outs.size() != 4) begin errors++; $display("FAIL ratio4_count got %0d want 4", dut_outs.size()); end
        for (int i = 0; i < 4 && i < dut_outs.size(); i++) begin
            checks++;
            if (dut_outs[i] !== e[i]) begin errors++; $display("FAIL ratio4_value idx=%0d got %0d want %0d", i, dut_outs[i], e[i]); end
        end
    endtask

    task automatic test_ratio_change();
        logic [15:0] e[4];
        e = '{16'd0, 16'd4, 16'd6, 16'd8};
        do_reset();
        ratio = 8'd4; tready = 1;
        for (int n = 0; n < 10; n++) begin
            ce = 1; din = 16'(n);
            cycle();
            if (n == 1) ratio = 8'd2;
        end
        ce = 0; cycle(); cycle();
        checks++;
        if (dut_outs.size() != 4) begin errors++; $display("FAIL ratio_change_count got %0d want 4", dut_outs.size()); end
        for (int i = 0; i < 4 && i < dut_outs.size(); i++) begin
            checks++;
            if (dut_outs[i] !== e[i]) begin errors++; $display("FAIL ratio_change_value idx=%0d got %0d want %0d", i, dut_outs[i], e[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ratio = 8'd1; tready = 0;
        for (int i = 0; i < 6; i++) begin
            ce = 1; din = 16'(10 + i);
            cycle();
            checks++;
            if (tvalid !== 1'b1 || tdata !== 16'd10) begin
                errors++; $display("FAIL bp_hold i=%0d got v=%b d=%0d want v=1 d=10", i, tvalid, tdata);
            end
        end
        ce = 0; cycle();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", ovf); end
        checks++; if (dcnt !== 16'd2) begin errors++; $display("FAIL bp_drop_count got %0d want 2", dcnt); end
        tready = 1;
        for (int k = 0; k < 6; k++) cycle();
        checks++;
        if (dut_outs.size() != 4) begin errors++; $display("FAIL bp_drain_count got %0d want 4", dut_outs.size()); end
        for (int i = 0; i < 4 && i < dut_outs.size(); i++) begin
            checks++;
            if (dut_outs[i] !== 16'(10 + i)) begin errors++; $display("FAIL bp_drain idx=%0d got %0d want %0d", i, dut_outs[i], 10 + i); end
        end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", tvalid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        ratio = 8'd1; tready = 0;
        for (int i = 0; i < 4; i++) begin ce = 1; din = 16'(20 + i); cycle(); end
        ce = 1; din = 16'd24; tready = 1; cycle();
        checks++; if (ovf !== 1'b0 || dcnt !== 16'd0) begin errors++; $display("FAIL full_pushpop_nodrop got ovf=%b cnt=%0d want 0/0", ovf, dcnt); end
        checks++; if (tvalid !== 1'b1 || tdata !== 16'd21) begin errors++; $display("FAIL full_pushpop_head got v=%b d=%0d want 1/21", tvalid, tdata); end
        tready = 0; din = 16'd25; cycle();
        checks++; if (ovf !== 1'b1 || dcnt !== 16'd1) begin errors++; $display("FAIL full_drop got ovf=%b cnt=%0d want 1/1", ovf, dcnt); end
        din = 16'd26; clear = 1; cycle();
        checks++; if (ovf !== 1'b1 || dcnt !== 16'd1) begin errors++; $display("FAIL clear_vs_drop got ovf=%b cnt=%0d want 1/1", ovf, dcnt); end
        ce = 0; cycle();
        checks++; if (ovf !== 1'b0 || dcnt !== 16'd0) begin errors++; $display("FAIL clear_only got ovf=%b cnt=%0d want 0/0", ovf, dcnt); end
        clear = 0;
        tready = 1;
        for (int k = 0; k < 5; k++) cycle();
        checks++;
        if (dut_outs.size() != 5 || dut_outs[4] !== 16'd24) begin
            errors++; $display("FAIL full_contents got n=%0d want 5 ending in 24", dut_outs.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ratio = 8'd1; tready = 0;
        for (int i = 0; i < 3; i++) begin ce = 1; din = 16'(30 + i); cycle(); end
        ce = 0;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b want 1", tvalid); end
        aresetn = 0;
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid got %b want 0", tvalid); end
        checks++; if (tdata !== 16'd0) begin errors++; $display("FAIL midreset_tdata got %0d want 0", tdata); end
        model_clear();
        @(negedge clk);
        aresetn = 1; ratio = 8'd3; tready = 1;
        ce = 1; din = 16'd40; cycle();
        checks++; if (tvalid !== 1'b1 || tdata !== 16'd40) begin errors++; $display("FAIL midreset_first got v=%b d=%0d want 1/40", tvalid, tdata); end
        ce = 0; cycle();
    endtask

    task automatic test_tlast();
`ifdef MA_DEC_TLAST_EN
        do_reset();
        ratio = 8'd1; tready = 1;
        for (int i = 0; i < 10; i++) begin
            ce = (i < 8); din = 16'(50 + i);
            cycle();
        end
        checks++;
        if (dut_lasts.size() != 8) begin errors++; $display("FAIL tlast_count got %0d want 8", dut_lasts.size()); end
        for (int i = 0; i < 8 && i < dut_lasts.size(); i++) begin
            checks++;
            if (dut_lasts[i] !== (i == 3 || i == 7)) begin
                errors++; $display("FAIL tlast_xfer n=%0d got %b want %b", i + 1, dut_lasts[i], (i == 3 || i == 7));
            end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) ratio = 8'($urandom_range(0, 5));
            ce     = ($urandom_range(0, 2) != 0);
            din    = 16'($urandom);
            tready = ($urandom_range(0, 3) != 0);
            clear  = ($urandom_range(0, 63) == 0);
            cycle();
            checks++;
            if (tvalid !== exp_valid || (exp_valid && tdata !== exp_data)) begin
                errors++; $display("FAIL random_data c=%0d got v=%b d=%h want v=%b d=%h", c, tvalid, tdata, exp_valid, exp_data);
            end
            checks++;
            if (ovf !== m_ovf || dcnt !== 16'(m_dcnt)) begin
                errors++; $display("FAIL random_ovf c=%0d got %b/%0d want %b/%0d", c, ovf, dcnt, m_ovf, m_dcnt);
            end
`ifdef MA_DEC_TLAST_EN
            checks++;
            if (exp_valid && tlast !== exp_last) begin
                errors++; $display("FAIL random_tlast c=%0d got %b want %b", c, tlast, exp_last);
            end
`endif
        end
        clear = 0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_ratio4();
        test_ratio_change();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        test_tlast();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
